// File: rtl/dino_game_ctrl.sv
// Frame-stepped controller for a side-scrolling dino runner: jump physics, one obstacle, BCD score.
// Optional macro SPEEDUP_EN: the obstacle step grows by the score's hundreds digit.
module dino_game_ctrl #(
    parameter int GROUND_V  = 400,
    parameter int JUMP_V0   = 12,
    parameter int OBS_SPEED = 4,
    parameter int SCORE_DIV = 6,
    parameter int OBS_START = 680
) (
    input  logic       dclk,
    input  logic       clr,
    input  logic       frame_tick,
    input  logic       btn_start,
    input  logic       btn_jump,
    output logic [9:0] dino_v,
    output logic [9:0] obstacle_h,
    output logic [9:0] obstacle_v,
    output logic [7:0] obstacle_height,
    output logic [7:0] obstacle_width,
    output logic [3:0] score3,
    output logic [3:0] score2,
    output logic [3:0] score1,
    output logic [3:0] score0,
    output logic       alive
);

    localparam int DINO_H     = 40;
    localparam int DINO_RIGHT = 40;
    localparam int OBS_W      = 20;
    localparam int OBS_HT     = 30;
    localparam int GROUND_TOP = 440;
    localparam int OBS_TOP    = GROUND_TOP - OBS_HT;
    localparam int CNT_W      = $clog2(SCORE_DIV + 1);

    typedef enum logic [1:0] {IDLE, RUN, JUMP, DEAD} state_t;

    state_t             state;
    logic signed [7:0]  vel;
    logic [CNT_W-1:0]   frame_cnt;
    logic               start_q;
    logic               jump_q;
    logic               start_pend;
    logic               jump_pend;
    logic               start_rise;
    logic               jump_rise;
    logic [9:0]         step;
    logic [9:0]         obs_next;
    logic [9:0]         dino_next;
    logic signed [10:0] jump_sum;
    logic               landing;
    logic               hit;
    logic               cnt_wrap;
    logic [15:0]        score_inc;

    assign obstacle_v      = 10'(OBS_TOP);
    assign obstacle_height = 8'(OBS_HT);
    assign obstacle_width  = 8'(OBS_W);

    assign start_rise = btn_start & ~start_q;
    assign jump_rise  = btn_jump & ~jump_q;

`ifdef SPEEDUP_EN
    assign step = 10'(OBS_SPEED) + {6'd0, score2};
`else
    assign step = 10'(OBS_SPEED);
`endif

    // Obstacle reloads offscreen rather than stepping past the left edge.
    assign obs_next = (obstacle_h < 10'(OBS_W) + step) ? 10'(OBS_START) : obstacle_h - step;

    assign jump_sum  = $signed({1'b0, dino_v}) - $signed({{3{vel[7]}}, vel});
    assign landing   = (state == JUMP) && (jump_sum >= $signed(11'(GROUND_V)));
    assign dino_next = (state != JUMP) ? dino_v :
                       landing         ? 10'(GROUND_V) : jump_sum[9:0];

    // obs_next never drops below OBS_W, so the width subtraction is folded into the constant.
    assign hit = (obs_next < 10'(DINO_RIGHT + OBS_W)) &&
                 (({1'b0, dino_next} + 11'(DINO_H)) > 11'(OBS_TOP));

    assign cnt_wrap = (frame_cnt == CNT_W'(SCORE_DIV - 1));

    always_comb begin
        score_inc = {score3, score2, score1, score0};
        if (!(score3 == 4'd9 && score2 == 4'd9 && score1 == 4'd9 && score0 == 4'd9)) begin
            if (score0 != 4'd9) begin
                score_inc[3:0] = score0 + 4'd1;
            end else begin
                score_inc[3:0] = 4'd0;
                if (score1 != 4'd9) begin
                    score_inc[7:4] = score1 + 4'd1;
                end else begin
                    score_inc[7:4] = 4'd0;
                    if (score2 != 4'd9) begin
                        score_inc[11:8] = score2 + 4'd1;
                    end else begin
                        score_inc[11:8]  = 4'd0;
                        score_inc[15:12] = score3 + 4'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            state      <= IDLE;
            dino_v     <= 10'(GROUND_V);
            vel        <= 8'sd0;
            obstacle_h <= 10'(OBS_START);
            score3     <= 4'd0;
            score2     <= 4'd0;
            score1     <= 4'd0;
            score0     <= 4'd0;
            frame_cnt  <= '0;
            start_q    <= 1'b0;
            jump_q     <= 1'b0;
            start_pend <= 1'b0;
            jump_pend  <= 1'b0;
            alive      <= 1'b1;
        end else begin
            start_q <= btn_start;
            jump_q  <= btn_jump;
            if (frame_tick) begin
                // Requests are consumed (or discarded) every tick; an edge on this very cycle waits for the next one.
                start_pend <= start_rise;
                jump_pend  <= jump_rise;
                case (state)
                    IDLE: begin
                        if (start_pend) begin
                            state      <= RUN;
                            obstacle_h <= 10'(OBS_START);
                            score3     <= 4'd0;
                            score2     <= 4'd0;
                            score1     <= 4'd0;
                            score0     <= 4'd0;
                            frame_cnt  <= '0;
                        end
                    end
                    RUN, JUMP: begin
                        obstacle_h <= obs_next;
                        dino_v     <= dino_next;
                        if (cnt_wrap) begin
                            frame_cnt <= '0;
                            {score3, score2, score1, score0} <= score_inc;
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                        if (state == JUMP) begin
                            vel <= vel - 8'sd1;
                        end
                        if (hit) begin
                            state <= DEAD;
                            alive <= 1'b0;
                        end else if (state == RUN && jump_pend) begin
                            state <= JUMP;
                            vel   <= 8'(JUMP_V0);
                        end else if (landing) begin
                            state <= RUN;
                        end
                    end
                    DEAD: begin
                        if (start_pend) begin
                            state      <= IDLE;
                            dino_v     <= 10'(GROUND_V);
                            vel        <= 8'sd0;
                            obstacle_h <= 10'(OBS_START);
                            alive      <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else begin
                if (start_rise) start_pend <= 1'b1;
                if (jump_rise) jump_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dino_game_ctrl.sv
// Scoreboard bench for dino_game_ctrl: a behavioural game model predicts outputs for every frame tick.
// SCORE_DIV is reduced to 2 so score saturation at 9999 is reachable in a short run.
module tb_dino_game_ctrl;

    localparam int GROUND_V     = 400;
    localparam int JUMP_V0      = 12;
    localparam int OBS_SPEED    = 4;
    localparam int SCORE_DIV_TB = 2;
    localparam int OBS_START    = 680;
    localparam int OBS_W        = 20;
    localparam int OBS_TOP      = 410;

    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_JUMP = 2;
    localparam int S_DEAD = 3;

    logic       dclk;
    logic       clr;
    logic       frame_tick;
    logic       btn_start;
    logic       btn_jump;
    logic [9:0] dino_v;
    logic [9:0] obstacle_h;
    logic [9:0] obstacle_v;
    logic [7:0] obstacle_height;
    logic [7:0] obstacle_width;
    logic [3:0] score3;
    logic [3:0] score2;
    logic [3:0] score1;
    logic [3:0] score0;
    logic       alive;

    typedef struct {
        int dino;
        int obs;
        int score_bcd;
        int alive;
    } exp_t;

    exp_t sb_q[$];

    int n_compared   = 0;
    int n_mismatched = 0;
    int tick_no      = 0;

    int m_state;
    int m_dino;
    int m_vel;
    int m_obs;
    int m_score;
    int m_cnt;
    bit m_spend;
    bit m_jpend;

    dino_game_ctrl #(
        .GROUND_V (GROUND_V),
        .JUMP_V0  (JUMP_V0),
        .OBS_SPEED(OBS_SPEED),
        .SCORE_DIV(SCORE_DIV_TB),
        .OBS_START(OBS_START)
    ) dut (
        .dclk           (dclk),
        .clr            (clr),
        .frame_tick     (frame_tick),
        .btn_start      (btn_start),
        .btn_jump       (btn_jump),
        .dino_v         (dino_v),
        .obstacle_h     (obstacle_h),
        .obstacle_v     (obstacle_v),
        .obstacle_height(obstacle_height),
        .obstacle_width (obstacle_width),
        .score3         (score3),
        .score2         (score2),
        .score1         (score1),
        .score0         (score0),
        .alive          (alive)
    );

    initial dclk = 1'b0;
    always #5 dclk = ~dclk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        n_compared++;
        if (observed != expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)",
                     tag, observed, observed, expected, expected);
        end
    endtask

    function automatic int toBcd(input int s);
        return ((s / 1000) << 12) | (((s / 100) % 10) << 8) | (((s / 10) % 10) << 4) | (s % 10);
    endfunction

    function automatic int dutScore();
        return int'({score3, score2, score1, score0});
    endfunction

    task automatic modelReset();
        m_state = S_IDLE;
        m_dino  = GROUND_V;
        m_vel   = 0;
        m_obs   = OBS_START;
        m_score = 0;
        m_cnt   = 0;
        m_spend = 0;
        m_jpend = 0;
    endtask

    task automatic modelTick();
        int  step;
        int  d;
        bit  land;
        bit  hit;
        step = OBS_SPEED;
`ifdef SPEEDUP_EN
        step = OBS_SPEED + (m_score / 100) % 10;
`endif
        case (m_state)
            S_IDLE: begin
                if (m_spend) begin
                    m_state = S_RUN;
                    m_score = 0;
                    m_cnt   = 0;
                    m_obs   = OBS_START;
                end
            end
            S_RUN, S_JUMP: begin
                m_obs = (m_obs < OBS_W + step) ? OBS_START : m_obs - step;
                d     = m_dino;
                land  = 0;
                if (m_state == S_JUMP) begin
                    d = m_dino - m_vel;
                    m_vel--;
                    if (d >= GROUND_V) begin
                        d    = GROUND_V;
                        land = 1;
                    end
                end
                m_dino = d;
                m_cnt++;
                if (m_cnt == SCORE_DIV_TB) begin
                    m_cnt = 0;
                    if (m_score < 9999) m_score++;
                end
                hit = (m_obs - OBS_W < 40) && (m_dino + 40 > OBS_TOP);
                if (hit) m_state = S_DEAD;
                else if (m_state == S_RUN && m_jpend) begin
                    m_state = S_JUMP;
                    m_vel   = JUMP_V0;
                end else if (m_state == S_JUMP && land) m_state = S_RUN;
            end
            S_DEAD: begin
                if (m_spend) begin
                    m_state = S_IDLE;
                    m_dino  = GROUND_V;
                    m_obs   = OBS_START;
                end
            end
            default: ;
        endcase
        m_spend = 0;
        m_jpend = 0;
    endtask

    // One frame tick: predict, push, let the DUT take the edge, then pop and compare.
    task automatic applyStimulus(input int gap);
        exp_t e;
        frame_tick = 1'b1;
        modelTick();
        sb_q.push_back('{m_dino, m_obs, toBcd(m_score), (m_state != S_DEAD) ? 1 : 0});
        @(posedge dclk);
        #1;
        frame_tick = 1'b0;
        tick_no++;
        e = sb_q.pop_front();
        checkOutput($sformatf("dino@%0d", tick_no), int'(dino_v), e.dino);
        checkOutput($sformatf("obs@%0d", tick_no), int'(obstacle_h), e.obs);
        checkOutput($sformatf("score@%0d", tick_no), dutScore(), e.score_bcd);
        checkOutput($sformatf("alive@%0d", tick_no), int'(alive), e.alive);
        repeat (gap) begin
            @(posedge dclk);
            #1;
        end
    endtask

    task automatic pressStart(input int width);
        if (!btn_start) m_spend = 1;
        btn_start = 1'b1;
        repeat (width) begin
            @(posedge dclk);
            #1;
        end
        btn_start = 1'b0;
    endtask

    task automatic pressJump(input int width);
        if (!btn_jump) m_jpend = 1;
        btn_jump = 1'b1;
        repeat (width) begin
            @(posedge dclk);
            #1;
        end
        btn_jump = 1'b0;
    endtask

    task automatic setJump(input bit level);
        if (level && !btn_jump) m_jpend = 1;
        btn_jump = level;
        @(posedge dclk);
        #1;
    endtask

    // Long-run tick that jumps just in time to clear each obstacle pass.
    task automatic runTick();
        applyStimulus(0);
        if (m_state == S_RUN && m_obs >= 64 && m_obs <= 72) pressJump(1);
        else begin
            @(posedge dclk);
            #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: observed timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int peak;
        clr        = 1'b1;
        frame_tick = 1'b0;
        btn_start  = 1'b0;
        btn_jump   = 1'b0;
        modelReset();
        repeat (2) @(posedge dclk);
        #1;
        checkOutput("rst_dino", int'(dino_v), 400);
        checkOutput("rst_obs", int'(obstacle_h), 680);
        checkOutput("rst_score", dutScore(), 0);
        checkOutput("rst_alive", int'(alive), 1);
        checkOutput("obs_v", int'(obstacle_v), 410);
        checkOutput("obs_height", int'(obstacle_height), 30);
        checkOutput("obs_width", int'(obstacle_width), 20);
        clr = 1'b0;
        @(posedge dclk);
        #1;

        repeat (3) applyStimulus(3);
        pressJump(1);
        repeat (2) applyStimulus(3);
        checkOutput("idle5_dino", int'(dino_v), 400);
        checkOutput("idle5_obs", int'(obstacle_h), 680);
        checkOutput("idle5_score", dutScore(), 0);
        checkOutput("idle5_alive", int'(alive), 1);

        pressStart(1);
        applyStimulus(3);
        applyStimulus(3);
        checkOutput("run_obs", int'(obstacle_h), 676);

        pressJump(1);
        applyStimulus(3);
        applyStimulus(3);
        checkOutput("jump_first", int'(dino_v), 388);
        applyStimulus(3);
        checkOutput("jump_second", int'(dino_v), 377);
        peak = int'(dino_v);
        for (int i = 3; i <= 25; i++) begin
            if (i == 10) pressJump(1);
            applyStimulus(3);
            if (int'(dino_v) < peak) peak = int'(dino_v);
        end
        checkOutput("jump_peak", peak, 322);
        checkOutput("jump_landed", int'(dino_v), 400);
        repeat (4) applyStimulus(3);

        setJump(1'b1);
        repeat (30) applyStimulus(2);
        setJump(1'b0);
        repeat (3) applyStimulus(2);

        n = 0;
        while (alive && n < 300) begin
            applyStimulus(2);
            n++;
        end
        checkOutput("dead_alive", int'(alive), 0);
        checkOutput("dead_obs_lt60", (obstacle_h < 10'd60) ? 1 : 0, 1);
        pressJump(1);
        repeat (3) applyStimulus(2);

        pressStart(1);
        applyStimulus(2);
        checkOutput("revive_obs", int'(obstacle_h), 680);
        pressStart(1);
        applyStimulus(2);

        pressJump(1);
        applyStimulus(2);
        n = 0;
        while (dino_v != 10'd350 && n < 10) begin
            applyStimulus(2);
            n++;
        end
        checkOutput("pre_clr_dino", int'(dino_v), 350);
        pressStart(1);
        pressJump(1);
        #3;
        clr = 1'b1;
        #1;
        checkOutput("clr_dino", int'(dino_v), 400);
        checkOutput("clr_obs", int'(obstacle_h), 680);
        checkOutput("clr_score", dutScore(), 0);
        checkOutput("clr_alive", int'(alive), 1);
        modelReset();
        @(posedge dclk);
        #1;
        clr = 1'b0;
        @(posedge dclk);
        #1;
        repeat (3) applyStimulus(2);
        checkOutput("clr_no_residual", int'(obstacle_h), 680);

        pressStart(1);
        applyStimulus(1);
        n = 0;
        while (m_score < 1000 && n < 3000) begin
            runTick();
            n++;
        end
        checkOutput("score_1000", dutScore(), 'h1000);
        n = 0;
        while (m_score < 9999 && n < 21000) begin
            runTick();
            n++;
        end
        repeat (10) runTick();
        checkOutput("score_sat", dutScore(), 'h9999);
        checkOutput("long_alive", int'(alive), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
